// File: rtl/motor_arm_controller.sv
// Motor arm/disarm sequencer with throttle ramp; watchdog failsafe descent when MOTOR_ARM_FAILSAFE_EN is defined.
// Latency: rate outputs register one cycle after a rate_valid strobe; state changes take one edge.
// Backpressure: none; rate_valid is a strobe and this block always accepts it.
module motor_arm_controller #(
  parameter int          ARM_HOLD_CYCLES  = 1000000,
  parameter int          WATCHDOG_CYCLES  = 2500000,
  parameter logic [15:0] RAMP_STEP        = 16'h0010,
  parameter logic [15:0] THROTTLE_ARM_MAX = 16'h0080,
  parameter int          DESCENT_PERIOD   = 250000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        arm_req,
  input  logic        disarm_req,
  input  logic        rate_valid,
  input  logic [15:0] throttle_in,
  input  logic [15:0] yaw_in,
  input  logic [15:0] roll_in,
  input  logic [15:0] pitch_in,
  output logic [15:0] throttle_rate,
  output logic [15:0] yaw_rate,
  output logic [15:0] roll_rate,
  output logic [15:0] pitch_rate,
  output logic        armed,
  output logic        failsafe,
  output logic [1:0]  ctrl_state
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

  localparam int HOLD_W = $clog2(ARM_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ARM_HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       ramp_q, ramp_d;
  logic [15:0]       thr_q, thr_d, yaw_q, yaw_d, roll_q, roll_d, pitch_q, pitch_d;

  logic        arm_ok;
  logic [15:0] thr_pos, thr_clamped, ramp_inc;
  logic [16:0] ramp_sum;

`ifdef MOTOR_ARM_FAILSAFE_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam int DC_W = $clog2(DESCENT_PERIOD + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DESCENT_PERIOD - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic [DC_W-1:0] dc_q, dc_d;
  logic [16:0]     thr_diff;
  logic [15:0]     thr_dec;

  // throttle is never negative here, so a borrow out means the step overshot zero
  assign thr_diff = {1'b0, thr_q} - {1'b0, RAMP_STEP};
  assign thr_dec  = thr_diff[16] ? 16'h0000 : thr_diff[15:0];
  assign failsafe = (state_q == FAILSAFE);
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(WATCHDOG_CYCLES), 32'(DESCENT_PERIOD)};
  assign failsafe   = 1'b0;
`endif

  assign arm_ok      = arm_req && ($signed(throttle_in) <= $signed(THROTTLE_ARM_MAX));
  assign thr_pos     = throttle_in[15] ? 16'h0000 : throttle_in;
  assign thr_clamped = ($signed(thr_pos) > $signed(ramp_q)) ? ramp_q : thr_pos;
  // ramp_limit stays in [0, 7FFF] and RAMP_STEP is a positive step, so a 17-bit sum cannot wrap
  assign ramp_sum    = {1'b0, ramp_q} + {1'b0, RAMP_STEP};
  assign ramp_inc    = (ramp_sum > 17'h07FFF) ? 16'h7FFF : ramp_sum[15:0];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ramp_d  = ramp_q;
    thr_d   = thr_q;
    yaw_d   = yaw_q;
    roll_d  = roll_q;
    pitch_d = pitch_q;
`ifdef MOTOR_ARM_FAILSAFE_EN
    wd_d    = wd_q;
    dc_d    = dc_q;
`endif
    if (disarm_req) begin
      state_d = DISARMED;
      hold_d  = '0;
      ramp_d  = '0;
      thr_d   = '0;
      yaw_d   = '0;
      roll_d  = '0;
      pitch_d = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          thr_d   = '0;
          yaw_d   = '0;
          roll_d  = '0;
          pitch_d = '0;
          if (arm_ok) begin
            state_d = ARMING;
            hold_d  = '0;
          end
        end
        ARMING: begin
          if (!arm_ok) begin
            state_d = DISARMED;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ARMED;
            ramp_d  = '0;
`ifdef MOTOR_ARM_FAILSAFE_EN
            wd_d    = '0;
`endif
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ARMED: begin
          // throttle is clamped against the limit as it stood before this strobe
          if (rate_valid) begin
            thr_d   = thr_clamped;
            yaw_d   = yaw_in;
            roll_d  = roll_in;
            pitch_d = pitch_in;
            ramp_d  = ramp_inc;
`ifdef MOTOR_ARM_FAILSAFE_EN
            wd_d    = '0;
          end else if (wd_q == WD_LAST) begin
            state_d = FAILSAFE;
            dc_d    = '0;
            yaw_d   = '0;
            roll_d  = '0;
            pitch_d = '0;
          end else begin
            wd_d = wd_q + 1'b1;
`endif
          end
        end
        FAILSAFE: begin
`ifdef MOTOR_ARM_FAILSAFE_EN
          if (thr_q == 16'h0000) begin
            state_d = DISARMED;
          end else if (dc_q == DC_LAST) begin
            dc_d  = '0;
            thr_d = thr_dec;
          end else begin
            dc_d = dc_q + 1'b1;
          end
`else
          state_d = DISARMED;
`endif
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= DISARMED;
      hold_q  <= '0;
      ramp_q  <= '0;
      thr_q   <= '0;
      yaw_q   <= '0;
      roll_q  <= '0;
      pitch_q <= '0;
`ifdef MOTOR_ARM_FAILSAFE_EN
      wd_q    <= '0;
      dc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ramp_q  <= ramp_d;
      thr_q   <= thr_d;
      yaw_q   <= yaw_d;
      roll_q  <= roll_d;
      pitch_q <= pitch_d;
`ifdef MOTOR_ARM_FAILSAFE_EN
      wd_q    <= wd_d;
      dc_q    <= dc_d;
`endif
    end
  end

  assign throttle_rate = thr_q;
  assign yaw_rate      = yaw_q;
  assign roll_rate     = roll_q;
  assign pitch_rate    = pitch_q;
  assign armed         = (state_q == ARMED);
  assign ctrl_state    = state_q;

endmodule

// File: tb/tb_motor_arm_controller.sv
// Bench for motor_arm_controller: directed sequences then randomized traffic, each cycle checked against a reference model.
module tb_motor_arm_controller;

  localparam int AHC = 4;
  localparam int WDC = 8;
  localparam int RS  = 16;
  localparam int DP  = 2;
  localparam int TAM = 128;
`ifdef MOTOR_ARM_FAILSAFE_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        reset, arm_req, disarm_req, rate_valid;
  logic [15:0] throttle_in, yaw_in, roll_in, pitch_in;
  logic [15:0] throttle_rate, yaw_rate, roll_rate, pitch_rate;
  logic        armed, failsafe;
  logic [1:0]  ctrl_state;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: plain integers, state numbers as the spec lists them
  int m_st, m_hold, m_ramp, m_wd, m_dc, m_thr, m_yaw, m_roll, m_pitch;

  motor_arm_controller #(
    .ARM_HOLD_CYCLES(AHC), .WATCHDOG_CYCLES(WDC), .RAMP_STEP(16'd16),
    .THROTTLE_ARM_MAX(16'd128), .DESCENT_PERIOD(DP)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .arm_req(arm_req), .disarm_req(disarm_req),
    .rate_valid(rate_valid), .throttle_in(throttle_in), .yaw_in(yaw_in),
    .roll_in(roll_in), .pitch_in(pitch_in), .throttle_rate(throttle_rate),
    .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
    .armed(armed), .failsafe(failsafe), .ctrl_state(ctrl_state)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int sx(input logic [15:0] v);
    return int'(signed'(v));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_outs();
    m_thr = 0; m_yaw = 0; m_roll = 0; m_pitch = 0;
  endtask

  // predicts the registered state after the coming clock edge from the current inputs
  task automatic model_step();
    int t;
    if (reset) begin
      m_st = 0; m_hold = 0; m_ramp = 0; m_wd = 0; m_dc = 0; zero_outs();
    end else if (disarm_req) begin
      m_st = 0; m_hold = 0; m_ramp = 0; zero_outs();
    end else begin
      case (m_st)
        0: begin
          zero_outs();
          if (arm_req && sx(throttle_in) <= TAM) begin m_st = 1; m_hold = 0; end
        end
        1: begin
          if (!(arm_req && sx(throttle_in) <= TAM)) m_st = 0;
          else if (m_hold + 1 == AHC) begin m_st = 2; m_ramp = 0; m_wd = 0; end
          else m_hold++;
        end
        2: begin
          if (rate_valid) begin
            t = sx(throttle_in);
            if (t < 0) t = 0;
            if (t > m_ramp) t = m_ramp;
            m_thr = t;
            m_yaw = sx(yaw_in); m_roll = sx(roll_in); m_pitch = sx(pitch_in);
            m_ramp = (m_ramp + RS > 32767) ? 32767 : m_ramp + RS;
            m_wd = 0;
          end else if (FS_EN) begin
            m_wd++;
            if (m_wd == WDC) begin
              m_st = 3; m_dc = 0; m_yaw = 0; m_roll = 0; m_pitch = 0;
            end
          end
        end
        3: begin
          if (m_thr == 0) m_st = 0;
          else begin
            m_dc++;
            if (m_dc == DP) begin
              m_dc = 0;
              m_thr = (m_thr - RS < 0) ? 0 : m_thr - RS;
            end
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic check_model();
    chk("state", {14'b0, ctrl_state}, 16'(m_st));
    chk("armed", {15'b0, armed}, {15'b0, (m_st == 2)});
    chk("failsafe", {15'b0, failsafe}, {15'b0, (m_st == 3)});
    chk("throttle", throttle_rate, 16'(m_thr));
    chk("yaw", yaw_rate, 16'(m_yaw));
    chk("roll", roll_rate, 16'(m_roll));
    chk("pitch", pitch_rate, 16'(m_pitch));
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
    check_model();
  endtask

  task automatic strobe();
    rate_valid = 1'b1;
    tick();
    rate_valid = 1'b0;
  endtask

  task automatic arm_up();
    reset = 1'b0; rate_valid = 1'b0; disarm_req = 1'b1;
    tick();
    disarm_req = 1'b0; arm_req = 1'b1; throttle_in = 16'h0000;
    repeat (5) tick();
    chk("arm_up_state", {14'b0, ctrl_state}, 16'd2);
  endtask

  int rv_pct[4];

  initial begin
    rv_pct = '{50, 12, 4, 90};
    reset = 1'b1; arm_req = 1'b1; disarm_req = 1'b0; rate_valid = 1'b1;
    throttle_in = 16'h0000; yaw_in = 16'h1234; roll_in = 16'h0011; pitch_in = 16'h0022;
    repeat (2) tick();
    chk("reset_state", {14'b0, ctrl_state}, 16'd0);
    chk("reset_thr", throttle_rate, 16'h0000);
    chk("reset_armed", {15'b0, armed}, 16'd0);

    // arming takes four ARMING cycles
    reset = 1'b0; rate_valid = 1'b0;
    repeat (4) tick();
    chk("arming_hold", {14'b0, ctrl_state}, 16'd1);
    tick();
    chk("armed_after_hold", {14'b0, ctrl_state}, 16'd2);
    chk("armed_flag", {15'b0, armed}, 16'd1);

    // arm_req dropped on the third cycle
    disarm_req = 1'b1; tick(); disarm_req = 1'b0;
    repeat (2) tick();
    arm_req = 1'b0; tick();
    chk("arm_abort_state", {14'b0, ctrl_state}, 16'd0);
    chk("arm_abort_thr", throttle_rate, 16'h0000);

    // THROTTLE_ARM_MAX boundary
    arm_req = 1'b1; throttle_in = 16'd129; tick();
    chk("arm_max_plus1", {14'b0, ctrl_state}, 16'd0);
    throttle_in = 16'd128; tick();
    chk("arm_max_exact", {14'b0, ctrl_state}, 16'd1);
    repeat (4) tick();
    chk("arm_max_armed", {14'b0, ctrl_state}, 16'd2);

    // ramp-limited throttle and passthrough axes
    throttle_in = 16'h0400; yaw_in = 16'hFFD0; roll_in = 16'h0055; pitch_in = 16'hFFFF;
    strobe(); chk("ramp0", throttle_rate, 16'h0000); chk("yaw_pass", yaw_rate, 16'hFFD0);
    strobe(); chk("ramp1", throttle_rate, 16'h0010);
    strobe(); chk("ramp2", throttle_rate, 16'h0020);
    tick();   chk("hold_between", throttle_rate, 16'h0020);
    strobe(); strobe(); chk("ramp4", throttle_rate, 16'h0040);

    // watchdog expiry and descent
    repeat (7) tick();
    chk("wd_7idle", {14'b0, ctrl_state}, 16'd2);
    tick();
`ifdef MOTOR_ARM_FAILSAFE_EN
    chk("wd_fs_state", {14'b0, ctrl_state}, 16'd3);
    chk("wd_fs_yaw", yaw_rate, 16'h0000);
    chk("wd_fs_flag", {15'b0, failsafe}, 16'd1);
    repeat (2) tick(); chk("descent1", throttle_rate, 16'h0030);
    repeat (2) tick(); chk("descent2", throttle_rate, 16'h0020);
    repeat (2) tick(); chk("descent3", throttle_rate, 16'h0010);
    repeat (2) tick(); chk("descent4", throttle_rate, 16'h0000);
    tick();
    chk("descent_done", {14'b0, ctrl_state}, 16'd0);
`else
    repeat (92) tick();
    chk("nofs_armed", {14'b0, ctrl_state}, 16'd2);
    chk("nofs_flag", {15'b0, failsafe}, 16'd0);
`endif

    // strobe on the expiry cycle keeps the arm
    arm_up();
    strobe();
    repeat (7) tick();
    strobe();
    chk("wd_race_state", {14'b0, ctrl_state}, 16'd2);
    repeat (7) tick();
    chk("wd_cleared", {14'b0, ctrl_state}, 16'd2);

    // disarm beats rate_valid
    throttle_in = 16'h0400; rate_valid = 1'b1; disarm_req = 1'b1;
    tick();
    rate_valid = 1'b0; disarm_req = 1'b0;
    chk("disarm_state", {14'b0, ctrl_state}, 16'd0);
    chk("disarm_thr", throttle_rate, 16'h0000);
    chk("disarm_yaw", yaw_rate, 16'h0000);

    // reset mid-flight (failsafe descent when enabled)
    arm_up();
    throttle_in = 16'h0400; yaw_in = 16'h0123;
    repeat (6) strobe();
    repeat (11) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_mid_state", {14'b0, ctrl_state}, 16'd0);
    chk("reset_mid_thr", throttle_rate, 16'h0000);
    chk("reset_mid_fs", {15'b0, failsafe}, 16'd0);

    // ramp saturation and negative throttle
    arm_up();
    throttle_in = 16'h7FFF; rate_valid = 1'b1;
    repeat (2050) tick();
    rate_valid = 1'b0;
    chk("ramp_sat", throttle_rate, 16'h7FFF);
    throttle_in = 16'hFFFB; strobe();
    chk("neg_throttle", throttle_rate, 16'h0000);

    // randomized traffic
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 300; c++) begin
        reset      = ($urandom_range(0, 399) == 0);
        disarm_req = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 19) == 0) arm_req = ~arm_req;
        rate_valid = ($urandom_range(0, 99) < rv_pct[p]);
        if ($urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 2))
            0: throttle_in = 16'($urandom_range(0, 200));
            1: throttle_in = 16'($urandom);
            default: throttle_in = 16'(-int'($urandom_range(1, 300)));
          endcase
        end
        yaw_in = 16'($urandom); roll_in = 16'($urandom); pitch_in = 16'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_arm_controller.md
MOTOR_ARM_CONTROLLER -- requirements
Module: motor_arm_controller

Interface
REQ-001 Parameter ARM_HOLD_CYCLES, default 1000000: consecutive qualifying cycles needed to arm.
REQ-002 Parameter WATCHDOG_CYCLES, default 2500000: cycles without rate_valid before failsafe.
REQ-003 Parameter RAMP_STEP, default 16'h0010 (1.0 in 12.4 fixed point): throttle ramp/descent step.
REQ-004 Parameter THROTTLE_ARM_MAX, default 16'h0080: highest throttle_in allowed while arming.
REQ-005 Parameter DESCENT_PERIOD, default 250000: cycles between failsafe throttle decrements.
REQ-006 sys_clk  in  1  system clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 arm_req  in  1  level; operator arm request.
REQ-009 disarm_req  in  1  level; operator disarm request.
REQ-010 rate_valid  in  1  one-cycle strobe; new PID rate set present on inputs.
REQ-011 throttle_in, yaw_in, roll_in, pitch_in  in  16 each  signed 12.4 rates from PID.
REQ-012 throttle_rate, yaw_rate, roll_rate, pitch_rate  out  16 each  signed 12.4 registered rates to motor mixer.
REQ-013 armed  out  1  high only in ARMED.
REQ-014 failsafe  out  1  high only in FAILSAFE.
REQ-015 ctrl_state  out  2  current state encoding.

Function
REQ-016 States SHALL be DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.
REQ-017 DISARMED: all four rate outputs SHALL be 0; arm_req=1 and throttle_in<=THROTTLE_ARM_MAX (signed compare) -> ARMING with hold counter=0.
REQ-018 ARMING: hold counter increments each cycle both conditions hold; when counter reaches ARM_HOLD_CYCLES-1 with conditions still true -> ARMED, ramp_limit=0, watchdog=0; either condition false -> DISARMED; outputs stay 0.
REQ-019 ARMED: on rate_valid, outputs SHALL update on the next clock edge (1-cycle latency): yaw/roll/pitch pass through; throttle_rate=min(max(throttle_in,0), ramp_limit).
REQ-020 ARMED: each rate_valid SHALL add RAMP_STEP to ramp_limit, saturating at 16'h7FFF; the min in REQ-019 uses the pre-increment ramp_limit.
REQ-021 ARMED: outputs SHALL hold their last values between rate_valid strobes.
REQ-022 ARMED: watchdog clears on rate_valid, else increments; reaching WATCHDOG_CYCLES -> FAILSAFE; rate_valid in the expiry cycle SHALL win (clear, stay ARMED).
REQ-023 FAILSAFE: yaw/roll/pitch SHALL be 0 from the first FAILSAFE cycle; throttle_rate SHALL decrease by RAMP_STEP every DESCENT_PERIOD cycles, saturating at 0; throttle_rate==0 -> DISARMED; rate_valid and arm_req ignored.
REQ-024 disarm_req=1 SHALL force DISARMED with all outputs 0 on the next edge from any state, with priority over arming, watchdog and rate_valid.
REQ-025 All arithmetic SHALL be 16-bit signed with explicit saturation; no wrap-around permitted.

Reset
REQ-026 reset=1 at a clock edge SHALL set state DISARMED, all rate outputs 0, armed=0, failsafe=0, all counters and ramp_limit 0, overriding every other input, including mid-ramp or mid-failsafe.

Configuration
REQ-027 Macro MOTOR_ARM_FAILSAFE_EN defined: watchdog, FAILSAFE state and descent logic SHALL be present per REQ-022/023.
REQ-028 Macro MOTOR_ARM_FAILSAFE_EN undefined: no watchdog or descent counters; ARMED SHALL persist until disarm_req or reset; failsafe tied 0; state 3 unreachable.

Verification (ARM_HOLD_CYCLES=4, WATCHDOG_CYCLES=8, RAMP_STEP=16, DESCENT_PERIOD=2, THROTTLE_ARM_MAX=128)
REQ-029 arm_req=1, throttle_in=0 for 5 cycles -> ARMED after 4 ARMING cycles; arm_req dropped on cycle 3 -> DISARMED, outputs 0.
REQ-030 ARMED, throttle_in=0x0400 with 3 rate_valid strobes -> throttle_rate 0x0000, 0x0010, 0x0020; yaw_in=-0x0030 -> yaw_rate 0xFFD0 one cycle after strobe.
REQ-031 ARMED, throttle_rate=0x0040, no rate_valid for 8 cycles -> FAILSAFE, yaw/roll/pitch 0, throttle 0x0030, 0x0020, 0x0010, 0x0000 every 2 cycles, then DISARMED.
REQ-032 rate_valid coincident with the 8th idle cycle -> stays ARMED, watchdog cleared.
REQ-033 disarm_req and rate_valid same cycle in ARMED -> DISARMED, outputs 0 next edge; reset asserted in FAILSAFE -> all outputs 0 next edge.
REQ-034 Build without MOTOR_ARM_FAILSAFE_EN, ARMED, 100 idle cycles -> remains ARMED, failsafe=0.
